// File: rtl/display_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : display_controller
// Purpose  : Sequential seven-segment display controller. A 32-bit value is
//            written with a single-cycle strobe and shown either as signed
//            decimal (iterative double-dabble, one bit per cycle) or as
//            unsigned hexadecimal (direct nibble extraction). The last
//            committed frame stays on the pins while a new value converts.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            wr_en, wr_data,      - write strobe, value, mode
//            wr_hex                 (0 = signed decimal, 1 = unsigned hex)
//            seg                  - NUM_DIGITS active-low digits, digit 0 LSB
//            sign_seg             - active-low sign digit ('-' when negative)
//            dot                  - decimal point, always off
//            busy                 - conversion running or value pending
//            done                 - one-cycle pulse after each frame commit
//            overflow             - committed value did not fit NUM_DIGITS
// Options  : DISPLAY_LZB_EN       - leading-zero blanking when defined
// Revision : 1.0 - initial release
// ============================================================================
module display_controller #(
  parameter int NUM_DIGITS = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_hex,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic [6:0]              sign_seg,
  output logic                    dot,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int BCD_NIBBLES = 10;
  localparam int BCD_WIDTH   = 4 * BCD_NIBBLES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   r_val;        // decimal: magnitude being shifted out; hex: raw value
  logic [BCD_WIDTH-1:0]    r_bcd;
  logic [4:0]              r_iter;
  logic                    r_hex;
  logic                    r_neg;
  logic                    r_pend_valid;
  logic [DATA_WIDTH-1:0]   r_pend_data;
  logic                    r_pend_hex;

  logic                    w_start;
  logic [DATA_WIDTH-1:0]   w_start_data;
  logic                    w_start_hex;
  logic [DATA_WIDTH-1:0]   w_mag;
  logic [BCD_WIDTH-1:0]    w_bcd_adj;
  logic [BCD_WIDTH-1:0]    w_nib;
  logic                    w_ovf;
  logic [7*NUM_DIGITS-1:0] w_seg;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110;
      4'hD: enc = 7'b0100001;
      4'hE: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction

  // Next-state and job selection. A write arriving in COMMIT beats the
  // pending entry, which is then dropped.
  always_comb begin
    state_nxt    = state;
    w_start      = 1'b0;
    w_start_data = wr_data;
    w_start_hex  = wr_hex;
    case (state)
      IDLE: begin
        if (wr_en) w_start = 1'b1;
      end
      SHIFT: begin
        if (r_iter == 5'd31) state_nxt = COMMIT;
      end
      COMMIT: begin
        if (wr_en) begin
          w_start = 1'b1;
        end else if (r_pend_valid) begin
          w_start      = 1'b1;
          w_start_data = r_pend_data;
          w_start_hex  = r_pend_hex;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (w_start) state_nxt = w_start_hex ? COMMIT : SHIFT;
  end

  // Two's-complement magnitude; -2^31 maps onto itself as unsigned 2^31.
  assign w_mag = w_start_data[DATA_WIDTH-1]
               ? (~w_start_data) + {{(DATA_WIDTH-1){1'b0}}, 1'b1}
               : w_start_data;

  // Double-dabble correction step applied before each left shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Frame construction from the finished job.
  always_comb begin
    w_nib = r_hex ? BCD_WIDTH'(r_val) : r_bcd;
    w_ovf = 1'b0;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (i >= NUM_DIGITS && w_nib[4*i +: 4] != 4'd0) w_ovf = 1'b1;
    end
    w_seg = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_seg[7*k +: 7] = w_ovf ? 7'b0111111 : enc(w_nib[4*k +: 4]);
    end
  end

`ifdef DISPLAY_LZB_EN
  logic [7*NUM_DIGITS-1:0] w_seg_out;
  logic                    w_lead;
  // Scan from the top digit down; blank until the first nonzero digit.
  // Digit 0 is outside the loop so zero still shows a single '0'.
  always_comb begin
    w_seg_out = w_seg;
    w_lead    = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (w_nib[4*k +: 4] != 4'd0) w_lead = 1'b1;
      if (!w_lead && !w_ovf) w_seg_out[7*k +: 7] = 7'h7F;
    end
  end
`else
  logic [7*NUM_DIGITS-1:0] w_seg_out;
  assign w_seg_out = w_seg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      r_val        <= '0;
      r_bcd        <= '0;
      r_iter       <= '0;
      r_hex        <= 1'b0;
      r_neg        <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_pend_hex   <= 1'b0;
      seg          <= '1;
      sign_seg     <= 7'h7F;
      overflow     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == COMMIT);

      if (w_start) begin
        r_hex  <= w_start_hex;
        r_neg  <= !w_start_hex && w_start_data[DATA_WIDTH-1];
        r_val  <= w_start_hex ? w_start_data : w_mag;
        r_bcd  <= '0;
        r_iter <= '0;
      end else if (state == SHIFT) begin
        {r_bcd, r_val} <= {w_bcd_adj, r_val} << 1;
        r_iter         <= r_iter + 5'd1;
      end

      // Pending entry is consumed or dropped at every COMMIT.
      if (state == SHIFT && wr_en) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= wr_data;
        r_pend_hex   <= wr_hex;
      end else if (state == COMMIT) begin
        r_pend_valid <= 1'b0;
      end

      if (state == COMMIT) begin
        seg      <= w_seg_out;
        sign_seg <= r_neg ? 7'b0111111 : 7'h7F;
        overflow <= w_ovf;
      end
    end
  end

  assign busy = (state != IDLE) || r_pend_valid;
  assign dot  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_display_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_display_controller
// Purpose  : Scoreboard bench for display_controller. Two instances are used:
//            NUM_DIGITS=10 and NUM_DIGITS=4. Stimulus pushes hand-computed
//            expected frames (digit nibbles, sign, overflow, commit edge);
//            monitors pop and compare on every done pulse.
// Options  : DISPLAY_LZB_EN - expected frames blank leading zeros when set
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en10 = 1'b0;
  logic        wr_en4 = 1'b0;
  logic        wr_hex = 1'b0;
  logic [31:0] wr_data = '0;

  logic [69:0] seg10;
  logic [6:0]  sign10;
  logic        dot10, busy10, done10, ovf10;
  logic [27:0] seg4;
  logic [6:0]  sign4;
  logic        dot4, busy4, done4, ovf4;

  display_controller #(.NUM_DIGITS(10), .DATA_WIDTH(32)) dut10 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en10), .wr_data(wr_data), .wr_hex(wr_hex),
    .seg(seg10), .sign_seg(sign10), .dot(dot10), .busy(busy10), .done(done10),
    .overflow(ovf10)
  );

  display_controller #(.NUM_DIGITS(4), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en4), .wr_data(wr_data), .wr_hex(wr_hex),
    .seg(seg4), .sign_seg(sign4), .dot(dot4), .busy(busy4), .done(done4),
    .overflow(ovf4)
  );

  always #5 clk = ~clk;

  int cyc = 0;                 // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done_cnt10 = 0;

  typedef struct packed {
    logic [69:0] seg;
    logic [6:0]  sign;
    logic        ovf;
    logic [31:0] at;
  } exp_t;

  exp_t q10[$];
  exp_t q4[$];

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [69:0] frame(input logic [39:0] nibs, input logic ovf, input int nd);
    logic [69:0] f;
    logic [39:0] up;
    f = '0;
    for (int k = 0; k < nd; k++) f[7*k +: 7] = ovf ? 7'b0111111 : enc(nibs[4*k +: 4]);
`ifdef DISPLAY_LZB_EN
    if (!ovf) begin
      for (int k = 1; k < nd; k++) begin
        up = nibs >> (4*k);
        if (up == 40'd0) f[7*k +: 7] = 7'h7F;
      end
    end
`endif
    return f;
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_frame(input bit d4, input logic [39:0] nibs, input logic neg,
                              input logic ovf, input int at);
    exp_t e;
    e.seg  = frame(nibs, ovf, d4 ? 4 : 10);
    e.sign = neg ? 7'b0111111 : 7'h7F;
    e.ovf  = ovf;
    e.at   = 32'(at);
    if (d4) q4.push_back(e);
    else    q10.push_back(e);
  endtask

  // Call at a falling edge; the write is sampled on the next rising edge.
  task automatic drive(input bit d4, input logic [31:0] d, input logic h, output int t0);
    wr_data = d;
    wr_hex  = h;
    wr_en10 = !d4;
    wr_en4  = d4;
    t0      = cyc + 1;
  endtask

  task automatic release_wr();
    @(negedge clk);
    wr_en10 = 1'b0;
    wr_en4  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy10 || busy4 || q10.size() != 0 || q4.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, q10=%0d q4=%0d",
               n, q10.size(), q4.size());
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon10
    exp_t e;
    if (rst_n && done10) begin
      done_cnt10++;
      if (q10.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done10_unexpected: done pulse with no expected frame at cycle %0d", cyc);
      end else begin
        e = q10.pop_front();
        chk("seg10", seg10, e.seg);
        chk("sign10", 70'(sign10), 70'(e.sign));
        chk("ovf10", 70'(ovf10), 70'(e.ovf));
        chk("commit_edge10", 70'(cyc), 70'(e.at));
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_unexpected: done pulse with no expected frame at cycle %0d", cyc);
      end else begin
        e = q4.pop_front();
        chk("seg4", 70'(seg4), 70'(e.seg[27:0]));
        chk("sign4", 70'(sign4), 70'(e.sign));
        chk("ovf4", 70'(ovf4), 70'(e.ovf));
        chk("commit_edge4", 70'(cyc), 70'(e.at));
      end
    end
  end

  initial begin
    int t, t2;
    bit gap;
    int dc;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seg10", seg10, {70{1'b1}});
    chk("rst_seg4", 70'(seg4), 70'({28{1'b1}}));
    chk("rst_sign10", 70'(sign10), 70'(7'h7F));
    chk("rst_ovf10", 70'(ovf10), 70'(1'b0));
    chk("rst_busy10", 70'(busy10), 70'(1'b0));
    chk("rst_done10", 70'(done10), 70'(1'b0));
    chk("dot10", 70'(dot10), 70'(1'b1));
    chk("dot4", 70'(dot4), 70'(1'b1));
    rst_n = 1'b1;

    // Decimal 1234
    @(negedge clk); drive(0, 32'd1234, 1'b0, t); release_wr();
    expect_frame(0, 40'h00_0000_1234, 1'b0, 1'b0, t + 33);
    wait_idle();

    // Most negative value
    @(negedge clk); drive(0, 32'h8000_0000, 1'b0, t); release_wr();
    expect_frame(0, 40'h21_4748_3648, 1'b1, 1'b0, t + 33);
    wait_idle();

    // Small negative, then zero
    @(negedge clk); drive(0, 32'hFFFF_FFF9, 1'b0, t); release_wr();
    expect_frame(0, 40'h7, 1'b1, 1'b0, t + 33);
    wait_idle();
    @(negedge clk); drive(0, 32'd0, 1'b0, t); release_wr();
    expect_frame(0, 40'h0, 1'b0, 1'b0, t + 33);
    wait_idle();

    // Hex on 10 digits
    @(negedge clk); drive(0, 32'h0000_BEEF, 1'b1, t); release_wr();
    expect_frame(0, 40'h00_0000_BEEF, 1'b0, 1'b0, t + 1);
    wait_idle();

    // Writes 5, 6, 7 on consecutive cycles: 6 is dropped
    @(negedge clk); drive(0, 32'd5, 1'b0, t);
    expect_frame(0, 40'h5, 1'b0, 1'b0, t + 33);
    expect_frame(0, 40'h7, 1'b0, 1'b0, t + 66);
    @(negedge clk); drive(0, 32'd6, 1'b0, t2);
    @(negedge clk); drive(0, 32'd7, 1'b0, t2);
    release_wr();
    gap = 1'b0;
    while (cyc <= t + 65) begin
      if (!busy10) gap = 1'b1;
      @(negedge clk);
    end
    chk("busy_held_567", 70'(gap), 70'(1'b0));
    chk("busy_drop_567", 70'(busy10), 70'(1'b0));
    wait_idle();

    // Write during COMMIT while a pending value is held: the new write wins
    @(negedge clk); drive(0, 32'd100, 1'b0, t);
    @(negedge clk); drive(0, 32'd200, 1'b0, t2);
    release_wr();
    while (cyc < t + 32) @(negedge clk);
    drive(0, 32'd300, 1'b0, t2);
    release_wr();
    expect_frame(0, 40'h100, 1'b0, 1'b0, t + 33);
    expect_frame(0, 40'h300, 1'b0, 1'b0, t + 66);
    wait_idle();

    // Four-digit instance: overflow, hex, hex overflow, negative
    @(negedge clk); drive(1, 32'd12345, 1'b0, t); release_wr();
    expect_frame(1, 40'h1_2345, 1'b0, 1'b1, t + 33);
    wait_idle();
    @(negedge clk); drive(1, 32'h0000_BEEF, 1'b1, t); release_wr();
    expect_frame(1, 40'hBEEF, 1'b0, 1'b0, t + 1);
    wait_idle();
    @(negedge clk); drive(1, 32'h0001_2345, 1'b1, t); release_wr();
    expect_frame(1, 40'h1_2345, 1'b0, 1'b1, t + 1);
    wait_idle();
    @(negedge clk); drive(1, 32'hFFFF_FFD6, 1'b0, t); release_wr();
    expect_frame(1, 40'h42, 1'b1, 1'b0, t + 33);
    wait_idle();

    // Reset in the middle of converting 999, with a pending value queued
    @(negedge clk); drive(0, 32'd999, 1'b0, t);
    @(negedge clk); drive(0, 32'd555, 1'b0, t2);
    release_wr();
    while (cyc < t + 16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg10", seg10, {70{1'b1}});
    chk("midrst_sign10", 70'(sign10), 70'(7'h7F));
    chk("midrst_busy10", 70'(busy10), 70'(1'b0));
    chk("midrst_ovf4", 70'(ovf4), 70'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt10;
    repeat (45) @(negedge clk);
    chk("postrst_no_done", 70'(done_cnt10 - dc), 70'(0));
    chk("postrst_busy10", 70'(busy10), 70'(1'b0));

    wait_idle();
    chk("q10_drained", 70'(q10.size()), 70'(0));
    chk("q4_drained", 70'(q4.size()), 70'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
